// File: rtl/snow64_bfloat16_int_cast_unit_pkg.sv
// Shared types and helpers for the Snow64 scalar integer<->BFloat16 cast unit.
// Optional build macro: SNOW64_BFLOAT16_ROUND_NEAREST_EN (used by the top).
package pkg_snow64_bfloat16;

   localparam int EXP_BIAS = 127;

   typedef struct packed {
      logic       sign;
      logic [7:0] enc_exp;
      logic [6:0] enc_mantissa;
   } bfloat16_t;

   typedef enum logic [1:0] {
      INT_SIZE_8  = 2'd0,
      INT_SIZE_16 = 2'd1,
      INT_SIZE_32 = 2'd2,
      INT_SIZE_64 = 2'd3
   } int_type_size_t;

   typedef enum logic {
      CAST_INT_TO_BF16 = 1'b0,
      CAST_BF16_TO_INT = 1'b1
   } cast_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_S1   = 2'd1,
      ST_S2   = 2'd2
   } cast_state_t;

   // Sign- or zero-extend the low sz bits of v to 65 bits.
   function automatic logic [64:0] extend_int(input logic [63:0] v,
                                              input int_type_size_t sz,
                                              input logic sgn);
      logic [64:0] r;
      case (sz)
         INT_SIZE_8:  r = {{57{sgn & v[7]}}, v[7:0]};
         INT_SIZE_16: r = {{49{sgn & v[15]}}, v[15:0]};
         INT_SIZE_32: r = {{33{sgn & v[31]}}, v[31:0]};
         default:     r = {sgn & v[63], v};
      endcase
      return r;
   endfunction

   // Largest unsigned value of the given integer width, zero-extended.
   function automatic logic [63:0] max_unsigned(input int_type_size_t sz);
      logic [63:0] r;
      case (sz)
         INT_SIZE_8:  r = 64'h0000_0000_0000_00FF;
         INT_SIZE_16: r = 64'h0000_0000_0000_FFFF;
         INT_SIZE_32: r = 64'h0000_0000_FFFF_FFFF;
         default:     r = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/snow64_bfloat16_int_cast_unit_if.sv
// Command/result bundle of the cast unit.
// Handshake: start is taken only in a cycle where can_accept_cmd=1; the result
// is announced by a one-cycle valid pulse with no backpressure, and the result
// registers hold until the next valid.
interface snow64_bfloat16_int_cast_unit_if;
   logic        start;
   logic        op;
   logic [1:0]  int_size;
   logic        is_signed;
   logic [63:0] int_in;
   logic [15:0] bf16_in;
   logic        can_accept_cmd;
   logic        valid;
   logic [15:0] bf16_out;
   logic [63:0] int_out;

   modport master (
      output start, op, int_size, is_signed, int_in, bf16_in,
      input  can_accept_cmd, valid, bf16_out, int_out
   );

   modport slave (
      input  start, op, int_size, is_signed, int_in, bf16_in,
      output can_accept_cmd, valid, bf16_out, int_out
   );
endinterface

// File: rtl/snow64_bfloat16_int_cast_unit_lzc.sv
// Combinational 64-bit leading-zero counter; an all-zero input yields 64.
module snow64_count_leading_zeros_64 (
   input  logic [63:0] data,
   output logic [6:0]  lz_count
);

   // Scan upward so the highest set bit wins.
   always_comb begin
      lz_count = 7'd64;
      for (int i = 0; i < 64; i++) begin
         if (data[i]) lz_count = 7'(63 - i);
      end
   end

endmodule

// File: rtl/snow64_bfloat16_int_cast_unit.sv
// Scalar integer<->BFloat16 cast unit, fixed 2-cycle latency (IDLE->S1->S2).
// S1 unpacks, takes |x| and counts leading zeros; S2 shifts/packs/rounds.
// Build option SNOW64_BFLOAT16_ROUND_NEAREST_EN: int->bf16 rounds to
// nearest-even instead of truncating.
module snow64_bfloat16_int_cast_unit
   import pkg_snow64_bfloat16::*;
(
   input  logic                             clk,
   input  logic                             rst_n,
   snow64_bfloat16_int_cast_unit_if.slave   bus,
   output cast_state_t                      dbg_state
);

   cast_state_t    state_q, state_d;
   cast_op_t       op_q;
   int_type_size_t size_q;
   logic           signed_q;
   logic [63:0]    int_src_q;
   bfloat16_t      bf_q;
   logic [63:0]    mag_q;
   logic           neg_q;
   logic [6:0]     lzc_q;
   logic           valid_q;
   logic [15:0]    bf16_res_q;
   logic [63:0]    int_res_q;

   wire accept = (state_q == ST_IDLE) && bus.start;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state: fixed walk through the two datapath stages.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start) state_d = ST_S1;
         ST_S1:   state_d = ST_S2;
         ST_S2:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand capture on an accepted command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= CAST_INT_TO_BF16;
         size_q    <= INT_SIZE_8;
         signed_q  <= 1'b0;
         int_src_q <= 64'd0;
         bf_q      <= '0;
      end else if (accept) begin
         op_q      <= cast_op_t'(bus.op);
         size_q    <= int_type_size_t'(bus.int_size);
         signed_q  <= bus.is_signed;
         int_src_q <= bus.int_in;
         bf_q      <= bus.bf16_in;
      end
   end

   // S1 datapath: extend, absolute value, leading-zero count.
   logic [64:0] ext;
   logic [63:0] mag_d;
   logic [6:0]  lzc_d;
   assign ext   = extend_int(int_src_q, size_q, signed_q);
   assign mag_d = ext[64] ? (~ext[63:0] + 64'd1) : ext[63:0];

   snow64_count_leading_zeros_64 u_lzc (
      .data     (mag_d),
      .lz_count (lzc_d)
   );

   // S1 stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_q <= 64'd0;
         neg_q <= 1'b0;
         lzc_q <= 7'd0;
      end else if (state_q == ST_S1) begin
         mag_q <= mag_d;
         neg_q <= ext[64];
         lzc_q <= lzc_d;
      end
   end

   // S2 int->bf16: normalise so the MSB lands at bit 63, then pack.
   logic [7:0]  norm_hi;
   logic        round_up;
`ifdef SNOW64_BFLOAT16_ROUND_NEAREST_EN
   logic [63:0] norm;
   assign norm     = mag_q << lzc_q;
   assign norm_hi  = norm[63:56];
   assign round_up = norm[55] & (norm[56] | (|norm[54:0]));
`else
   assign norm_hi  = 8'((mag_q << lzc_q) >> 56);
   assign round_up = 1'b0;
`endif
   logic [7:0]  mant_sum;
   logic [5:0]  msb_pos;
   logic [7:0]  exp_w;
   logic [15:0] bf16_res;
   assign mant_sum = {1'b0, norm_hi[6:0]} + {7'd0, round_up};
   assign msb_pos  = 6'(7'd63 - lzc_q);
   assign exp_w    = 8'(EXP_BIAS) + {2'b00, msb_pos} + {7'd0, mant_sum[7]};
   assign bf16_res = norm_hi[7] ? {neg_q, exp_w, mant_sum[6:0]} : 16'h0000;

   // S2 bf16->int: scale {1,mant} by exp-134, truncate, then saturate.
   logic [7:0]  unb_exp;
   logic [5:0]  sh;
   logic [63:0] sig64;
   logic [63:0] mag_i;
   logic [63:0] lim_u;
   logic [63:0] lim_s;
   logic        is_nan;
   logic        is_small;
   logic        is_ovf;
   assign unb_exp  = bf_q.enc_exp - 8'(EXP_BIAS);
   assign sh       = unb_exp[5:0];
   assign sig64    = {56'd0, 1'b1, bf_q.enc_mantissa};
   assign mag_i    = (sh >= 6'd7) ? (sig64 << (sh - 6'd7)) : (sig64 >> (6'd7 - sh));
   assign is_nan   = (&bf_q.enc_exp) & (|bf_q.enc_mantissa);
   assign is_small = bf_q.enc_exp < 8'(EXP_BIAS);
   assign is_ovf   = (&bf_q.enc_exp) | (unb_exp >= 8'd64);
   assign lim_u    = max_unsigned(size_q);
   assign lim_s    = lim_u >> 1;

   logic [63:0] int_res;
   // Range selection; in-range values are already correctly extended to 64b.
   always_comb begin
      int_res = 64'd0;
      if (is_nan || is_small) begin
         int_res = 64'd0;
      end else if (bf_q.sign) begin
         if (!signed_q)                              int_res = 64'd0;
         else if (is_ovf || (mag_i > lim_s + 64'd1)) int_res = ~lim_s;
         else                                        int_res = 64'd0 - mag_i;
      end else if (signed_q) begin
         int_res = (is_ovf || (mag_i > lim_s)) ? lim_s : mag_i;
      end else begin
         int_res = (is_ovf || (mag_i > lim_u)) ? lim_u : mag_i;
      end
   end

   // Result registers: only the register of the executed op is updated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         bf16_res_q <= 16'h0000;
         int_res_q  <= 64'd0;
      end else begin
         valid_q <= (state_q == ST_S2);
         if (state_q == ST_S2) begin
            if (op_q == CAST_INT_TO_BF16) bf16_res_q <= bf16_res;
            else                          int_res_q  <= int_res;
         end
      end
   end

   assign bus.can_accept_cmd = (state_q == ST_IDLE);
   assign bus.valid          = valid_q;
   assign bus.bf16_out       = bf16_res_q;
   assign bus.int_out        = int_res_q;
   assign dbg_state          = state_q;

endmodule

// File: tb/tb_snow64_bfloat16_int_cast_unit.sv
// Directed self-checking bench for snow64_bfloat16_int_cast_unit.
module tb_snow64_bfloat16_int_cast_unit;
   import pkg_snow64_bfloat16::*;

   logic        clk;
   logic        rst_n;
   cast_state_t dbg_state;
   int          checks;
   int          failures;

   snow64_bfloat16_int_cast_unit_if bus ();

   snow64_bfloat16_int_cast_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net against a hung run.
   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input logic op, input logic [1:0] sz, input logic sgn,
                          input logic [63:0] iv, input logic [15:0] bv);
      bus.start     = 1'b1;
      bus.op        = op;
      bus.int_size  = sz;
      bus.is_signed = sgn;
      bus.int_in    = iv;
      bus.bf16_in   = bv;
   endtask

   // One full command with latency checks, then the result check.
   task automatic run(input string tag, input logic op, input logic [1:0] sz,
                      input logic sgn, input logic [63:0] iv, input logic [15:0] bv,
                      input logic [63:0] exp);
      check({tag, "_ready"}, 64'(bus.can_accept_cmd), 64'd1);
      set_cmd(op, sz, sgn, iv, bv);
      tick();
      bus.start = 1'b0;
      check({tag, "_busy"}, 64'(bus.can_accept_cmd), 64'd0);
      tick();
      check({tag, "_novalid"}, 64'(bus.valid), 64'd0);
      tick();
      check({tag, "_valid"}, 64'(bus.valid), 64'd1);
      if (op) check(tag, bus.int_out, exp);
      else    check(tag, 64'(bus.bf16_out), exp);
      tick();
      check({tag, "_pulse"}, 64'(bus.valid), 64'd0);
   endtask

   initial begin
      logic [63:0] exp_round;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.start = 1'b0; bus.op = 1'b0; bus.int_size = 2'd0; bus.is_signed = 1'b0;
      bus.int_in = 64'd0; bus.bf16_in = 16'd0;

      // Reset state.
      repeat (3) tick();
      check("rst_ready", 64'(bus.can_accept_cmd), 64'd1);
      check("rst_valid", 64'(bus.valid), 64'd0);
      check("rst_bf16",  64'(bus.bf16_out), 64'd0);
      check("rst_int",   bus.int_out, 64'd0);
      check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      rst_n = 1'b1;
      tick();

      // int -> bf16.
      run("i2f_s32_one",  1'b0, 2'd2, 1'b1, 64'd1, 16'h0, 64'h3F80);
      run("i2f_s8_m1",    1'b0, 2'd0, 1'b1, 64'hDEAD_0000_0000_00FF, 16'h0, 64'hBF80);
      run("i2f_u16_300",  1'b0, 2'd1, 1'b0, 64'd300, 16'h0, 64'h4396);
      run("i2f_u64_zero", 1'b0, 2'd3, 1'b0, 64'd0, 16'h0, 64'h0000);
`ifdef SNOW64_BFLOAT16_ROUND_NEAREST_EN
      exp_round = 64'h4400;
`else
      exp_round = 64'h43FF;
`endif
      run("i2f_u64_511",  1'b0, 2'd3, 1'b0, 64'd511, 16'h0, exp_round);
      run("i2f_s64_min",  1'b0, 2'd3, 1'b1, 64'h8000_0000_0000_0000, 16'h0, 64'hDF00);
      check("hold_int_after_i2f", bus.int_out, 64'd0);

      // bf16 -> int.
      run("f2i_s8_75",     1'b1, 2'd0, 1'b1, 64'd0, 16'h4296, 64'h4B);
      run("f2i_s64_m75",   1'b1, 2'd3, 1'b1, 64'd0, 16'hC296, 64'hFFFF_FFFF_FFFF_FFB5);
      check("hold_bf16_after_f2i", 64'(bus.bf16_out), 64'hDF00);
      run("f2i_u32_neg",   1'b1, 2'd2, 1'b0, 64'd0, 16'hC296, 64'd0);
      run("f2i_s16_inf",   1'b1, 2'd1, 1'b1, 64'd0, 16'h7F80, 64'h7FFF);
      run("f2i_s32_nan",   1'b1, 2'd2, 1'b1, 64'd0, 16'h7FC0, 64'd0);
      run("f2i_u16_sat",   1'b1, 2'd1, 1'b0, 64'd0, 16'h4780, 64'hFFFF);
      run("f2i_s32_half",  1'b1, 2'd2, 1'b1, 64'd0, 16'h3F00, 64'd0);
      run("f2i_s16_sat",   1'b1, 2'd1, 1'b1, 64'd0, 16'h4780, 64'h7FFF);
      run("f2i_s8_ninf",   1'b1, 2'd0, 1'b1, 64'd0, 16'hFF80, 64'hFFFF_FFFF_FFFF_FF80);
      run("f2i_s8_m256",   1'b1, 2'd0, 1'b1, 64'd0, 16'hC380, 64'hFFFF_FFFF_FFFF_FF80);

      // Start while busy is ignored.
      set_cmd(1'b0, 2'd2, 1'b1, 64'd1, 16'h0);
      tick();
      set_cmd(1'b0, 2'd2, 1'b1, 64'd2, 16'h0);
      check("busy_ready", 64'(bus.can_accept_cmd), 64'd0);
      tick();
      bus.start = 1'b0;
      check("busy_novalid", 64'(bus.valid), 64'd0);
      tick();
      check("busy_valid", 64'(bus.valid), 64'd1);
      check("busy_result", 64'(bus.bf16_out), 64'h3F80);
      tick();
      check("busy_after1", 64'(bus.valid), 64'd0);
      tick();
      check("busy_after2", 64'(bus.valid), 64'd0);
      check("busy_state", 64'(dbg_state), 64'(ST_IDLE));

      // Back-to-back start in the valid cycle.
      set_cmd(1'b0, 2'd2, 1'b1, 64'd1, 16'h0);
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      check("b2b_valid_a", 64'(bus.valid), 64'd1);
      check("b2b_ready_a", 64'(bus.can_accept_cmd), 64'd1);
      check("b2b_result_a", 64'(bus.bf16_out), 64'h3F80);
      set_cmd(1'b0, 2'd1, 1'b0, 64'd300, 16'h0);
      tick();
      bus.start = 1'b0;
      check("b2b_accepted", 64'(bus.can_accept_cmd), 64'd0);
      check("b2b_pulse", 64'(bus.valid), 64'd0);
      tick();
      check("b2b_novalid_b", 64'(bus.valid), 64'd0);
      tick();
      check("b2b_valid_b", 64'(bus.valid), 64'd1);
      check("b2b_result_b", 64'(bus.bf16_out), 64'h4396);
      tick();

      // Reset during S1 aborts the operation.
      set_cmd(1'b1, 2'd0, 1'b1, 64'd0, 16'h4296);
      tick();
      bus.start = 1'b0;
      check("abort_in_s1", 64'(dbg_state), 64'(ST_S1));
      rst_n = 1'b0;
      #1;
      check("abort_ready", 64'(bus.can_accept_cmd), 64'd1);
      check("abort_valid", 64'(bus.valid), 64'd0);
      check("abort_bf16_cleared", 64'(bus.bf16_out), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("abort_no_valid", 64'(bus.valid), 64'd0);
      end
      check("abort_int_cleared", bus.int_out, 64'd0);
      check("abort_idle", 64'(dbg_state), 64'(ST_IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
